// File: rtl/encrypt_scheduler.sv
// encrypt_scheduler
//   Shares one 8-bit encrypter datapath between two byte requesters.
//   It arbitrates round-robin, holds the private key, and registers each
//   result in an output stage with a valid/ready handshake.
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   keyLoad, keyIn        load a new private key (blocks grants that cycle)
//   req0Valid/Data/Ready  requester 0 byte handshake (Ready combinational)
//   req1Valid/Data/Ready  requester 1 byte handshake (Ready combinational)
//   outValid/Data/Src     registered encrypted byte and its requester index
//   outReady              downstream accepts outData
//   byteCount             bytes granted since reset, wraps at 8 bits
//
// Configuration macro
//   KEY_ROLL_EN  when defined, the key rotates left by one after every grant
//                (keyLoad still wins); otherwise it changes only on keyLoad.

module encrypt_byte (
   input  logic [7:0] msg,
   input  logic [7:0] key,
   output logic [7:0] enc
);
   logic [7:0] perm;

   always_comb begin
      perm[0] = ~msg[0];
      perm[1] =  msg[3];
      perm[2] = ~msg[2];
      perm[3] =  msg[5];
      perm[4] = ~msg[4];
      perm[5] =  msg[1];
      perm[6] = ~msg[6];
      perm[7] =  msg[7];
      enc     = perm ^ key;
   end
endmodule

// state | meaning
// EMPTY | output register holds nothing, outValid = 0
// FULL  | output register holds a result, outValid = 1
module encrypt_scheduler (
   input  logic       clk,
   input  logic       reset,
   input  logic       keyLoad,
   input  logic [7:0] keyIn,
   input  logic       req0Valid,
   input  logic [7:0] req0Data,
   output logic       req0Ready,
   input  logic       req1Valid,
   input  logic [7:0] req1Data,
   output logic       req1Ready,
   output logic       outValid,
   output logic [7:0] outData,
   output logic       outSrc,
   input  logic       outReady,
   output logic [7:0] byteCount
);
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0] state;
   logic [7:0] key;
   logic       rr_ptr;
   logic       can_accept;
   logic       grant;
   logic       grant_idx;
   logic [7:0] grant_data;
   logic [7:0] enc_data;

   // A key load takes the whole cycle so the next byte sees the new key.
   always_comb begin
      can_accept = ((state == EMPTY) || outReady) && !keyLoad;
      grant      = 1'b0;
      grant_idx  = 1'b0;
      if (can_accept) begin
         if (req0Valid && req1Valid) begin
            grant     = 1'b1;
            grant_idx = rr_ptr;
         end else if (req0Valid) begin
            grant     = 1'b1;
            grant_idx = 1'b0;
         end else if (req1Valid) begin
            grant     = 1'b1;
            grant_idx = 1'b1;
         end
      end
      req0Ready  = grant && !grant_idx;
      req1Ready  = grant &&  grant_idx;
      grant_data = grant_idx ? req1Data : req0Data;
   end

   encrypt_byte u_encrypt_byte (
      .msg (grant_data),
      .key (key),
      .enc (enc_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= EMPTY;
         outData   <= 8'h00;
         outSrc    <= 1'b0;
         byteCount <= 8'h00;
         rr_ptr    <= 1'b0;
      end else begin
         if (grant) begin
            state     <= FULL;
            outData   <= enc_data;
            outSrc    <= grant_idx;
            byteCount <= byteCount + 8'd1;
            rr_ptr    <= ~grant_idx;
         end else if ((state == FULL) && outReady) begin
            state <= EMPTY;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key <= 8'h00;
      end else if (keyLoad) begin
         key <= keyIn;
`ifdef KEY_ROLL_EN
      end else if (grant) begin
         key <= {key[6:0], key[7]};
`endif
      end
   end

   assign outValid = (state == FULL);
endmodule
